// File: rtl/quote_update_sequencer_pkg.sv
// Shared order-book constants, the book_entry record and the sequencer state enum.
// Used by every file of the quote update sequencer.
package quote_update_sequencer_pkg;

    localparam int STOCK_INDEX     = 2;
    localparam int PRICE_INDEX     = 15;
    localparam int ORDER_INDEX     = 7;
    localparam int QUANTITY_INDEX  = 7;
    localparam int NUM_STOCK_INDEX = 3;

    localparam logic [2:0] ADD_ORDER    = 3'd1;
    localparam logic [2:0] CANCEL_ORDER = 3'd2;

    typedef struct packed {
        logic [PRICE_INDEX:0]    price;
        logic [ORDER_INDEX:0]    order_id;
        logic [QUANTITY_INDEX:0] quantity;
    } book_entry;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CANCEL,
        S_WAIT_C,
        S_ADD,
        S_WAIT_A
    } seq_state_t;

    // Order ids run 1..all-ones and wrap back to 1; id 0 is reserved.
    function automatic logic [ORDER_INDEX:0] next_order_id(input logic [ORDER_INDEX:0] id);
        return (&id) ? {{ORDER_INDEX{1'b0}}, 1'b1} : id + 1'b1;
    endfunction

endpackage

// File: rtl/quote_update_sequencer_if.sv
// Update stream and order-book command bus of the quote update sequencer.
// QUOTE_DEDUP_EN adds the dup_count drop counter.
interface quote_update_sequencer_if
    import quote_update_sequencer_pkg::*;
    #(parameter int NUM_STOCKS = 4);

    logic                    upd_valid;
    logic                    upd_ready;
    logic [STOCK_INDEX:0]    upd_stock;
    logic [PRICE_INDEX:0]    upd_price;
    logic [STOCK_INDEX:0]    stock_to_add;
    book_entry               entry;
    logic                    start;
    logic [2:0]              request;
    logic [ORDER_INDEX:0]    order_id;
    logic                    delete;
    logic [QUANTITY_INDEX:0] quantity;
    logic                    book_busy;
    logic [NUM_STOCKS-1:0]   live_mask;
    logic                    idle;
`ifdef QUOTE_DEDUP_EN
    logic [15:0]             dup_count;
`endif

    modport master (
`ifdef QUOTE_DEDUP_EN
        output dup_count,
`endif
        input  upd_valid, upd_stock, upd_price, book_busy,
        output upd_ready, stock_to_add, entry, start, request, order_id,
               delete, quantity, live_mask, idle
    );

    modport slave (
`ifdef QUOTE_DEDUP_EN
        input  dup_count,
`endif
        output upd_valid, upd_stock, upd_price, book_busy,
        input  upd_ready, stock_to_add, entry, start, request, order_id,
               delete, quantity, live_mask, idle
    );

endinterface

// File: rtl/quote_update_sequencer_fifo.sv
// Synchronous show-ahead FIFO buffering {stock, price} updates.
// The head word is visible on o_rd_data whenever o_empty is low.
module quote_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/quote_update_sequencer.sv
// Turns buffered per-stock quote updates into cancel/add replace sequences for the order book.
// Optional QUOTE_DEDUP_EN drops updates that repeat a stock's live price.
module quote_update_sequencer
    import quote_update_sequencer_pkg::*;
#(
    parameter int NUM_STOCKS = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ORDER_QTY  = 1
) (
    input  logic                     clk_100mhz,
    input  logic                     rst_n,
    quote_update_sequencer_if.master bus
);

    localparam int SW     = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int FIFO_W = (STOCK_INDEX + 1) + (PRICE_INDEX + 1);
    localparam logic [QUANTITY_INDEX:0] QTY = ORDER_QTY[QUANTITY_INDEX:0];

    seq_state_t              r_state;
    logic [STOCK_INDEX:0]    r_stock;
    logic [PRICE_INDEX:0]    r_price;
    logic [ORDER_INDEX:0]    r_order_ctr;
    logic [ORDER_INDEX:0]    r_live_id [NUM_STOCKS];
    logic [NUM_STOCKS-1:0]   r_live_mask;
    logic                    r_start;
    logic [2:0]              r_request;
    logic [STOCK_INDEX:0]    r_stock_to_add;
    book_entry               r_entry;
    logic [ORDER_INDEX:0]    r_order_id;
    logic                    r_delete;
    logic [QUANTITY_INDEX:0] r_quantity;

    logic [FIFO_W-1:0]       w_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_pop;
    logic [STOCK_INDEX:0]    w_cur_stock;
    logic [PRICE_INDEX:0]    w_cur_price;
    logic [SW-1:0]           w_idx;
    logic                    w_stock_ok;
    logic                    w_live;
    logic                    w_drop;
    logic                    w_cancel_load;
    logic                    w_add_load;

    quote_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_100mhz),
        .rst_n     (rst_n),
        .i_wr_en   (bus.upd_valid),
        .i_wr_data ({bus.upd_stock, bus.upd_price}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_pop = (r_state == S_POP);

    // In POP the decision is made on the FIFO head; later states use the captured copy.
    assign w_cur_stock = w_pop ? w_head[FIFO_W-1:PRICE_INDEX+1] : r_stock;
    assign w_cur_price = w_pop ? w_head[PRICE_INDEX:0]          : r_price;
    assign w_idx       = w_cur_stock[SW-1:0];
    assign w_stock_ok  = (32'(w_cur_stock) < NUM_STOCKS);
    assign w_live      = w_stock_ok && r_live_mask[w_idx];

    assign w_cancel_load = w_pop && w_stock_ok && !w_drop && w_live;
    assign w_add_load    = (w_pop && w_stock_ok && !w_drop && !w_live) ||
                           ((r_state == S_WAIT_C) && !bus.book_busy);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_stock        <= '0;
            r_price        <= '0;
            r_order_ctr    <= {{ORDER_INDEX{1'b0}}, 1'b1};
            r_start        <= 1'b0;
            r_request      <= ADD_ORDER;
            r_stock_to_add <= '0;
            r_entry        <= '0;
            r_order_id     <= '0;
            r_delete       <= 1'b0;
            r_quantity     <= '0;
        end else begin
            r_start <= 1'b0;
            if (w_pop) begin
                r_stock <= w_cur_stock;
                r_price <= w_cur_price;
            end
            if (w_cancel_load) begin
                r_start        <= 1'b1;
                r_request      <= CANCEL_ORDER;
                r_delete       <= 1'b1;
                r_stock_to_add <= w_cur_stock;
                r_order_id     <= r_live_id[w_idx];
                r_quantity     <= QTY;
            end
            if (w_add_load) begin
                r_start          <= 1'b1;
                r_request        <= ADD_ORDER;
                r_delete         <= 1'b0;
                r_stock_to_add   <= w_cur_stock;
                r_entry.price    <= w_cur_price;
                r_entry.order_id <= r_order_ctr;
                r_entry.quantity <= QTY;
                r_quantity       <= QTY;
                r_order_ctr      <= next_order_id(r_order_ctr);
            end
            case (r_state)
                S_IDLE:   if (!w_fifo_empty) r_state <= S_POP;
                S_POP: begin
                    if (!w_stock_ok || w_drop) r_state <= S_IDLE;
                    else if (w_live)           r_state <= S_CANCEL;
                    else                       r_state <= S_ADD;
                end
                S_CANCEL: r_state <= S_WAIT_C;
                S_WAIT_C: if (!bus.book_busy) r_state <= S_ADD;
                S_ADD:    r_state <= S_WAIT_A;
                S_WAIT_A: if (!bus.book_busy) r_state <= w_fifo_empty ? S_IDLE : S_POP;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_live_mask <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) r_live_id[i] <= '0;
        end else if (w_add_load) begin
            r_live_mask[w_idx] <= 1'b1;
            r_live_id[w_idx]   <= r_order_ctr;
        end
    end

`ifdef QUOTE_DEDUP_EN
    logic [PRICE_INDEX:0] r_live_price [NUM_STOCKS];
    logic [15:0]          r_dup_count;

    assign w_drop = w_live && (r_live_price[w_idx] == w_cur_price);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_dup_count <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) r_live_price[i] <= '0;
        end else begin
            if (w_pop && w_stock_ok && w_drop && !(&r_dup_count)) begin
                r_dup_count <= r_dup_count + 1'b1;
            end
            if (w_add_load) r_live_price[w_idx] <= w_cur_price;
        end
    end

    assign bus.dup_count = r_dup_count;
`else
    assign w_drop = 1'b0;
`endif

    assign bus.upd_ready    = !w_fifo_full;
    assign bus.start        = r_start;
    assign bus.request      = r_request;
    assign bus.stock_to_add = r_stock_to_add;
    assign bus.entry        = r_entry;
    assign bus.order_id     = r_order_id;
    assign bus.delete       = r_delete;
    assign bus.quantity     = r_quantity;
    assign bus.live_mask    = r_live_mask;
    assign bus.idle         = (r_state == S_IDLE) && w_fifo_empty;

endmodule

// File: tb/tb_quote_update_sequencer.sv
// Directed scoreboard bench for quote_update_sequencer with a simple busy-book model.
// Build with QUOTE_DEDUP_EN defined to cover the duplicate-drop path.
module tb_quote_update_sequencer;
    import quote_update_sequencer_pkg::*;

    localparam int NS    = 4;
    localparam int DEPTH = 8;
`ifdef QUOTE_DEDUP_EN
    localparam int T6_ADDS = 1;
`else
    localparam int T6_ADDS = 2;
`endif

    typedef struct packed {
        logic                 is_cancel;
        logic [STOCK_INDEX:0] stock;
        logic [PRICE_INDEX:0] price;
        logic [ORDER_INDEX:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    quote_update_sequencer_if #(.NUM_STOCKS(NS)) bus ();

    quote_update_sequencer #(
        .NUM_STOCKS (NS),
        .FIFO_DEPTH (DEPTH),
        .ORDER_QTY  (1)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int cancel_cyc = 0;
    int add_cyc = 0;
    int n_cancel = 0;
    int n_add = 0;
    int last_add_id = 0;
    bit prev_start = 1'b0;
    bit hold_busy = 1'b0;
    bit busy_rand = 1'b0;
    int busy_len = 0;
    int busy_cnt = 0;

    exp_t sb[$];
    bit                   m_live  [NS];
    logic [ORDER_INDEX:0] m_id    [NS];
    logic [PRICE_INDEX:0] m_price [NS];
    logic [ORDER_INDEX:0] m_ctr;
    int                   m_dup;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        for (int s = 0; s < NS; s++) begin
            m_live[s]  = 1'b0;
            m_id[s]    = '0;
            m_price[s] = '0;
        end
        m_ctr = 8'd1;
        m_dup = 0;
    endtask

    // Expected command sequence of one accepted update.
    task automatic model_push(input logic [STOCK_INDEX:0] s, input logic [PRICE_INDEX:0] p);
        exp_t e;
        bit   dropped;
        dropped = 1'b0;
        if (int'(s) < NS) begin
`ifdef QUOTE_DEDUP_EN
            if (m_live[s] && m_price[s] == p) begin
                dropped = 1'b1;
                m_dup++;
            end
`endif
            if (!dropped) begin
                if (m_live[s]) begin
                    e = '{is_cancel: 1'b1, stock: s, price: p, id: m_id[s]};
                    sb.push_back(e);
                end
                e = '{is_cancel: 1'b0, stock: s, price: p, id: m_ctr};
                sb.push_back(e);
                m_id[s]    = m_ctr;
                m_price[s] = p;
                m_live[s]  = 1'b1;
                m_ctr      = (m_ctr == 8'hFF) ? 8'd1 : m_ctr + 8'd1;
            end
        end
    endtask

    task automatic send(input logic [STOCK_INDEX:0] s, input logic [PRICE_INDEX:0] p);
        int w;
        w = 0;
        @(negedge clk);
        bus.upd_valid = 1'b1;
        bus.upd_stock = s;
        bus.upd_price = p;
        while (bus.upd_ready !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) check("upd_accept_timeout", 64'(bus.upd_ready), 64'd1);
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        bus.upd_valid = 1'b0;
        model_push(s, p);
        $display("upd cyc=%0d stock=%0d price=%04h", wr_cyc, s, p);
    endtask

    task automatic drain(input string tag);
        int  w;
        bit  done;
        w    = 0;
        done = 1'b0;
        while (!done && w < 3000) begin
            @(negedge clk);
            w++;
            done = (sb.size() == 0) && (bus.idle === 1'b1);
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Book model: busy for busy_len (or random 0-7) sampled edges starting with the start cycle.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            busy_cnt      = 0;
            bus.book_busy = 1'b0;
        end else if (hold_busy) begin
            bus.book_busy = 1'b1;
        end else begin
            if (bus.start === 1'b1) busy_cnt = busy_rand ? int'($urandom_range(0, 7)) : busy_len;
            else if (busy_cnt > 0)  busy_cnt--;
            bus.book_busy = (busy_cnt > 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.start === 1'b1) begin
            check("start_gap", 64'(prev_start), 64'd0);
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.is_cancel) begin
                    n_cancel++;
                    cancel_cyc = cyc;
                    $display("cmd cyc=%0d CANCEL stock=%0d id=%0d", cyc, bus.stock_to_add, bus.order_id);
                    check("cancel_cmd",
                          64'({bus.request, bus.stock_to_add, bus.delete, bus.order_id, bus.quantity}),
                          64'({CANCEL_ORDER, e.stock, 1'b1, e.id, 8'd1}));
                end else begin
                    n_add++;
                    add_cyc     = cyc;
                    last_add_id = int'(bus.entry.order_id);
                    $display("cmd cyc=%0d ADD stock=%0d price=%04h id=%0d", cyc, bus.stock_to_add,
                             bus.entry.price, bus.entry.order_id);
                    check("add_cmd",
                          64'({bus.request, bus.stock_to_add, bus.delete, bus.entry}),
                          64'({ADD_ORDER, e.stock, 1'b0, e.price, e.id, 8'd1}));
                end
            end
        end
        prev_start = (rst_n === 1'b1) && (bus.start === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, a0, w;
        rst_n         = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_stock = '0;
        bus.upd_price = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_start",     64'(bus.start),     64'd0);
        check("rst_request",   64'(bus.request),   64'(ADD_ORDER));
        check("rst_live_mask", 64'(bus.live_mask), 64'd0);
        check("rst_idle",      64'(bus.idle),      64'd1);
        check("rst_upd_ready", 64'(bus.upd_ready), 64'd1);
        check("rst_cmd_zero",  64'({bus.entry, bus.order_id, bus.delete, bus.quantity, bus.stock_to_add}), 64'd0);

        // Single add on an idle stock, book never busy
        busy_len = 0;
        send(3'd2, 16'h2267);
        drain("t1_drain");
        check("t1_latency",   64'(add_cyc - wr_cyc), 64'd2);
        check("t1_no_cancel", 64'(n_cancel),         64'd0);
        check("t1_live_mask", 64'(bus.live_mask),    64'h4);

        // Replace on a live stock with a 5-cycle busy book
        busy_len = 5;
        send(3'd2, 16'h1F00);
        drain("t2_drain");
        check("t2_cancel_to_add", 64'(add_cyc - cancel_cyc), 64'd6);
        check("t2_add_id",        64'(last_add_id),          64'd2);

        // Four rounds over all stocks, random book latency
        do_reset();
        busy_rand = 1'b1;
        c0 = n_cancel;
        a0 = n_add;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < NS; s++) begin
                send(3'(s), {4'(r), 4'(s), 8'($urandom)});
            end
        end
        drain("t3_drain");
        check("t3_cancels",   64'(n_cancel - c0), 64'd12);
        check("t3_adds",      64'(n_add - a0),    64'd16);
        check("t3_idle",      64'(bus.idle),      64'd1);
        check("t3_live_mask", 64'(bus.live_mask), 64'hF);

        // Fill the FIFO behind a stalled book; stock 5 is out of range
        hold_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("t4_ready_fill", 64'(bus.upd_ready), 64'd1);
            send((i == 3) ? 3'd5 : 3'(i % NS), 16'h9000 + 16'(i));
        end
        check("t4_ready_full", 64'(bus.upd_ready), 64'd0);
        hold_busy = 1'b0;
        send(3'(DEPTH + 1), 16'h9000 + 16'(DEPTH + 1));
        drain("t4_drain");
        check("t4_live_mask", 64'(bus.live_mask), 64'hF);

        // Reset while waiting on the book after a cancel
        busy_rand = 1'b0;
        busy_len  = 20;
        c0 = n_cancel;
        send(3'd1, 16'h4444);
        w = 0;
        while (n_cancel == c0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("t5_cancel_seen", 64'(n_cancel - c0), 64'd1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_start",     64'(bus.start),     64'd0);
        check("t5_rst_request",   64'(bus.request),   64'(ADD_ORDER));
        check("t5_rst_cmd_zero",  64'({bus.delete, bus.order_id, bus.quantity}), 64'd0);
        check("t5_rst_live_mask", 64'(bus.live_mask), 64'd0);
        check("t5_rst_idle",      64'(bus.idle),      64'd1);
        check("t5_rst_ready",     64'(bus.upd_ready), 64'd1);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        busy_len = 0;
        c0 = n_cancel;
        send(3'd1, 16'h3000);
        drain("t5_drain");
        check("t5_no_cancel", 64'(n_cancel - c0), 64'd0);
        check("t5_add_id",    64'(last_add_id),   64'd1);

        // Same price twice on one stock
        a0 = n_add;
        send(3'd0, 16'h7F00);
        send(3'd0, 16'h7F00);
        drain("t6_drain");
        check("t6_adds", 64'(n_add - a0), 64'(T6_ADDS));
`ifdef QUOTE_DEDUP_EN
        check("t6_dup_count", 64'(bus.dup_count), 64'(m_dup));
        check("t6_dup_one",   64'(bus.dup_count), 64'd1);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/quote_update_sequencer.md
Name: quote_update_sequencer

Overview:
- Sits directly upstream of the order-book top level and drives its `stock_to_add` / `entry` / `start` / `request` / `order_id` / `delete` / `quantity` command interface.
- Accepts per-stock quote price updates through a valid/ready stream and buffers them in a FIFO.
- Turns each update into the book's replace sequence: cancel the stock's live order, then add a new order at the new price.
- Polls `book_busy` between commands so only one command is ever outstanding.

Parameters:
- NUM_STOCKS, 4, number of stocks tracked; must equal NUM_STOCK_INDEX+1.
- FIFO_DEPTH, 8, update buffer depth; power of two, minimum 2.
- ORDER_QTY, 1, quantity placed on every added order.

Ports:
- clk_100mhz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  price update offered.
- upd_ready  out  1  FIFO can accept the update.
- upd_stock  in  STOCK_INDEX+1  stock number of the update.
- upd_price  in  PRICE_INDEX+1  new price, 8.8 fixed point.
- stock_to_add  out  STOCK_INDEX+1  target stock of the current command.
- entry  out  book_entry  {price, order_id, quantity}; meaningful for ADD_ORDER only.
- start  out  1  one-cycle command strobe.
- request  out  3  ADD_ORDER or CANCEL_ORDER.
- order_id  out  ORDER_INDEX+1  id to cancel.
- delete  out  1  high with CANCEL_ORDER.
- quantity  out  QUANTITY_INDEX+1  cancel quantity; driven to ORDER_QTY.
- book_busy  in  1  order book is processing a command.
- live_mask  out  NUM_STOCKS  bit s set = stock s has a live order.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset values: all command outputs 0, `request` = ADD_ORDER, `live_mask` = 0, `idle` = 1, `upd_ready` = 1, FIFO empty, order-id counter = 1.
- FIFO write side:
  - An update is written when `upd_valid` and `upd_ready` are both high.
  - `upd_ready` = !full.
  - Read and write in the same cycle are legal when full; a full FIFO does not take the write.
- FSM states: IDLE, POP, CANCEL, WAIT_C, ADD, WAIT_A.
- IDLE -> POP when the FIFO is non-empty.
- POP: pop the head into the working registers (stock, price). Go to CANCEL if `live_mask[stock]` is set, else go to ADD.
- CANCEL:
  - Drive `start`=1, `request`=CANCEL_ORDER, `delete`=1, `order_id` = live_id[stock] for exactly one cycle.
  - Next state is WAIT_C.
- WAIT_C:
  - Entered the cycle after `start`; `book_busy` is sampled from this cycle on.
  - Exit to ADD on the first cycle `book_busy` = 0, including the first WAIT_C cycle.
- ADD:
  - Drive `start`=1, `request`=ADD_ORDER, `delete`=0, `entry` = {price, order-id counter, ORDER_QTY} for one cycle.
  - Write the counter value into live_id[stock] and set `live_mask[stock]`.
  - Increment the counter, wrapping from all-ones to 1; 0 is never issued.
  - Next state is WAIT_A.
- WAIT_A: identical to WAIT_C; exit to IDLE, or directly to POP if the FIFO is non-empty.
- Command outputs are held stable from the `start` cycle until the next command; `start` is never high in two consecutive cycles.
- Latency from FIFO non-empty to the first `start`: 2 cycles (IDLE, POP).
- Updates for the same stock are processed strictly in order; there is no coalescing.
- `upd_stock` >= NUM_STOCKS: the update is accepted and discarded at POP; no command is issued.
- Asynchronous reset mid-sequence:
  - Aborts immediately and clears FIFO, `live_mask` and the counter.
  - The book shares the same reset, so no cancel is issued after reset.

Optional Feature:
- Macro: QUOTE_DEDUP_EN.
- Defined:
  - Keeps live_price[s].
  - At POP, an update whose stock is live and whose price equals live_price is dropped with no command issued.
  - A 16-bit saturating output `dup_count` counts drops; reset value 0.
- Undefined: every valid update issues a command sequence; `dup_count` port and live_price storage are absent.

Decomposition:
- Shared constants package (existing `constants.sv`) holds:
  - STOCK_INDEX, PRICE_INDEX, ORDER_INDEX, QUANTITY_INDEX, NUM_STOCK_INDEX.
  - The book_entry typedef.
  - ADD_ORDER and CANCEL_ORDER codes.
- Add the FSM state enum `seq_state_t` to the same package.
- One sub-module: `quote_fifo` (parameterised synchronous FIFO carrying {stock, price}, with full/empty flags).

Test Plan:
- Reset, then one update {stock 2, price 0x2267}, `book_busy` held low -> no cancel is issued; one ADD with `entry` = {0x2267, 1, 1} on `stock_to_add` 2, 2 cycles after the write; `live_mask` = 4'b0100.
- Second update {stock 2, price 0x1F00}, `book_busy` high for 5 cycles after each `start` -> CANCEL with `order_id` 1, then ADD with `order_id` 2; the ADD `start` occurs exactly 6 cycles after the CANCEL `start`.
- Four updates per stock, 4 stocks, 4 rounds, written back-to-back with `book_busy` random 0-7 cycles -> every ADD price matches the input order per stock; 12 cancels and 16 adds; `idle`=1 at the end.
- Hold `book_busy` high and write FIFO_DEPTH+2 updates -> `upd_ready` falls once 8 entries are buffered; no update is lost after `book_busy` is released.
- Assert `rst_n` low during WAIT_C -> outputs are at reset values in the same cycle; the next update for that stock issues an ADD only, with `order_id` 1.
- With QUOTE_DEDUP_EN, send {stock 0, price 0x7F00} twice -> only one ADD is issued; `dup_count` = 1.
